// File: rtl/button_array.sv
// Multi-channel debounced button array with auto-repeat and per-channel wrapping indices.
// ivsync rising edges form the frame time base; presses commit on release or via auto-repeat.
module button_array #(
  parameter int unsigned NUM_BTN      = 3,
  parameter int unsigned IDX_W        = 8,
  parameter int unsigned WRAP_MAX     = 255,
  parameter int unsigned DEB_FRAMES   = 7,
  parameter int unsigned REPEAT_DELAY = 30,
  parameter int unsigned REPEAT_RATE  = 6
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ivsync,
  input  logic [NUM_BTN-1:0]       ibtn,
  input  logic [NUM_BTN-1:0]       idir,
  input  logic                     iclr,
  output logic [NUM_BTN*IDX_W-1:0] oindex,
  output logic [NUM_BTN-1:0]       ostep,
  output logic [NUM_BTN-1:0]       ohold
);

  localparam int unsigned CntMax0 = (DEB_FRAMES > REPEAT_DELAY) ? DEB_FRAMES : REPEAT_DELAY;
  localparam int unsigned CntMax  = (CntMax0 > REPEAT_RATE) ? CntMax0 : REPEAT_RATE;
  // Counter only ever holds 0..CntMax-1.
  localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0]  DebLast  = CntW'(DEB_FRAMES - 1);
  localparam logic [CntW-1:0]  DlyLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0]  RateLast = CntW'(REPEAT_RATE - 1);
  localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(WRAP_MAX - 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRepeat} state_e;

  logic [1:0]         vs_q;
  logic               tick;
  logic [NUM_BTN-1:0] btn_meta_q, btn_s_q;
  logic [NUM_BTN-1:0] step, step_q;
  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CntW-1:0]    cnt_q   [NUM_BTN];
  logic [CntW-1:0]    cnt_d   [NUM_BTN];
  logic [IDX_W-1:0]   idx_q   [NUM_BTN];
  logic [IDX_W-1:0]   idx_d   [NUM_BTN];

  assign tick = vs_q[0] & ~vs_q[1];

  always_comb begin
    step = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        StIdle: begin
          if (!btn_s_q[k]) begin
            state_d[k] = StDebounce;
            cnt_d[k]   = '0;
          end
        end
        StDebounce: begin
          // Release aborts even if a tick lands in the same cycle.
          if (btn_s_q[k]) begin
            state_d[k] = StIdle;
          end else if (tick) begin
            if (cnt_q[k] == DebLast) begin
              state_d[k] = StPressed;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
        StPressed: begin
          if (btn_s_q[k]) begin
            step[k]    = 1'b1;
            state_d[k] = StIdle;
          end else if (tick) begin
            if (cnt_q[k] == DlyLast) begin
              step[k]    = 1'b1;
              state_d[k] = StRepeat;
              cnt_d[k]   = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
        StRepeat: begin
          if (btn_s_q[k]) begin
            state_d[k] = StIdle;
          end else if (tick) begin
            if (cnt_q[k] == RateLast) begin
              step[k]  = 1'b1;
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
        default: begin
          state_d[k] = StIdle;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BTN; k++) begin
      idx_d[k] = idx_q[k];
      if (iclr) begin
        idx_d[k] = '0;
      end else if (step[k]) begin
        if (idir[k]) begin
          idx_d[k] = (idx_q[k] == '0) ? IdxLast : idx_q[k] - 1'b1;
        end else begin
          idx_d[k] = (idx_q[k] == IdxLast) ? '0 : idx_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      vs_q       <= '0;
      btn_meta_q <= '0;
      btn_s_q    <= '0;
      step_q     <= '0;
      for (int k = 0; k < NUM_BTN; k++) begin
        state_q[k] <= StIdle;
        cnt_q[k]   <= '0;
        idx_q[k]   <= '0;
      end
    end else begin
      vs_q       <= {vs_q[0], ivsync};
      btn_meta_q <= ibtn;
      btn_s_q    <= btn_meta_q;
      step_q     <= step & {NUM_BTN{~iclr}};
      for (int k = 0; k < NUM_BTN; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
        idx_q[k]   <= idx_d[k];
      end
    end
  end

  always_comb begin
    oindex = '0;
    ohold  = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      oindex[k*IDX_W +: IDX_W] = idx_q[k];
      ohold[k] = (state_q[k] == StPressed) || (state_q[k] == StRepeat);
    end
  end

  assign ostep = step_q;

endmodule
